gray_counter_codec: RTL

// - Parametrised, registered Gray-code counter with a companion registered Gray->binary decoder.
// - Supplies one-bit-change pointers for clock-domain-crossing FIFOs and position counters.
// - Decodes Gray values that arrive back from a synchroniser into binary.
// - Adds up/down counting, parallel load, a wrap flag and a valid-qualified decode path.

---
 rtl/gray_counter_codec.sv | 100 ++++++++++
 1 files changed

// File: rtl/gray_counter_codec.sv
// Gray-code counter with a companion Gray->binary decoder.
// The counter keeps a single binary state. The Gray output is registered from
// the same next-state value, so the two outputs always describe the same count.
// The decoder is a separate registered path with a valid qualifier.
module gray_counter_codec #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_in_valid,
  output logic [WIDTH-1:0] dec_bin,
  output logic             dec_valid
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ZERO    = '0;

  // Adjacent binary values differ by a single bit in this encoding.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;
  logic [WIDTH-1:0] dec_bin_q;
  logic             dec_valid_q;

  // Counter next state: load beats count enable, otherwise hold.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_next  = bin_q + ONE;
        wrap_next = (bin_q == MAX_VAL);
      end else begin
        bin_next  = bin_q - ONE;
        wrap_next = (bin_q == ZERO);
      end
    end
  end

  // Count state register; Gray is derived from the same next value so it never lags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RST_VAL;
      gray_q <= bin2gray(RST_VAL);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= bin2gray(bin_next);
      wrap_q <= wrap_next;
    end
  end

  // Decode register: result captured only for valid samples, valid flag follows input.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_bin_q   <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      dec_valid_q <= gray_in_valid;
      if (gray_in_valid) begin
        dec_bin_q <= gray2bin(gray_in);
      end
    end
  end

  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign wrap      = wrap_q;
  assign dec_bin   = dec_bin_q;
  assign dec_valid = dec_valid_q;

endmodule
